// File: rtl/cla_pkg.sv
// Shared carry-lookahead definitions: group width and a 4-bit lookahead slice
// usable by any arithmetic block that needs one.
package cla_pkg;

    localparam int GROUP_W = 4;

    // Returns {cout, carry_into_bit3, sum[3:0]} with every carry fully expanded.
    function automatic logic [5:0] cla4(
        input logic [3:0] a,
        input logic [3:0] b,
        input logic       cin
    );
        logic [3:0] p;
        logic [3:0] g;
        logic       c1;
        logic       c2;
        logic       c3;
        logic       c4;
        p  = a ^ b;
        g  = a & b;
        c1 = g[0] | (p[0] & cin);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & cin);
        return {c4, c3, p ^ {c3, c2, c1, cin}};
    endfunction

endpackage

// File: rtl/cla4_group.sv
// One 4-bit carry-lookahead slice; exposes the carry into its top bit so the
// most significant slice can feed signed-overflow detection.
module cla4_group
    import cla_pkg::*;
(
    input  logic [GROUP_W-1:0] a,
    input  logic [GROUP_W-1:0] b,
    input  logic               cin,
    output logic [GROUP_W-1:0] sum,
    output logic               cout,
    output logic               c3
);

    assign {cout, c3, sum} = cla4(a, b, cin);

endmodule

// File: rtl/cla_adder_pipe.sv
// Pipelined carry-lookahead adder/subtractor: each stage resolves a slice of
// 4-bit groups and forwards partial sum, carry and the still-pending operand bits.
module cla_adder_pipe
    import cla_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int NG  = WIDTH / GROUP_W;
    localparam int GPS = NG / STAGES;
    localparam int SW  = GPS * GROUP_W;

    logic              en_s;
    logic [WIDTH-1:0]  b_eff_s;
    logic              c0_s;
    logic [STAGES-1:0] valid_r;
    logic [STAGES-1:0] vin_s;

    // Subtraction is A + ~B + 1; the external carry-in is ignored in that mode.
    always_comb begin
        if (in_sub) begin
            b_eff_s = ~in_b;
            c0_s    = 1'b1;
        end else begin
            b_eff_s = in_b;
            c0_s    = in_cin;
        end
    end

    // The whole pipe advances together, so a held output freezes every stage.
    assign en_s     = ~valid_r[STAGES-1] | out_ready;
    assign in_ready = en_s;

    if (STAGES > 1) begin : g_vin
        assign vin_s = {valid_r[STAGES-2:0], in_valid};
    end else begin : g_vin
        assign vin_s = in_valid;
    end

    // Valid bits shift on every enabled cycle; bubbles travel like data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= {STAGES{1'b0}};
        end else if (en_s) begin
            valid_r <= vin_s;
        end else begin
            valid_r <= valid_r;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * SW;
        localparam int IW = WIDTH - LO;

        logic [IW-1:0]    a_in_s;
        logic [IW-1:0]    b_in_s;
        logic             c_in_s;
        logic [GPS:0]     c_chain_s;
        logic [GPS-1:0]   c3_s;
        logic [SW-1:0]    grp_sum_s;
        logic [LO+SW-1:0] sum_nxt_s;
        logic [LO+SW-1:0] sum_r;
        logic             carry_r;
        logic             unused_c3_s;

        if (k == 0) begin : g_src
            assign a_in_s    = in_a;
            assign b_in_s    = b_eff_s;
            assign c_in_s    = c0_s;
            assign sum_nxt_s = grp_sum_s;
        end else begin : g_src
            assign a_in_s    = g_stage[k-1].g_ops.a_rem_r;
            assign b_in_s    = g_stage[k-1].g_ops.b_rem_r;
            assign c_in_s    = g_stage[k-1].carry_r;
            assign sum_nxt_s = {grp_sum_s, g_stage[k-1].sum_r};
        end

        assign c_chain_s[0] = c_in_s;
        assign unused_c3_s  = ^c3_s;

        for (genvar g = 0; g < GPS; g++) begin : g_grp
            cla4_group u_grp (
                .a    (a_in_s[g*GROUP_W +: GROUP_W]),
                .b    (b_in_s[g*GROUP_W +: GROUP_W]),
                .cin  (c_chain_s[g]),
                .sum  (grp_sum_s[g*GROUP_W +: GROUP_W]),
                .cout (c_chain_s[g+1]),
                .c3   (c3_s[g])
            );
        end

        // Result registers load only with a valid op, so they hold through bubbles.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sum_r   <= {(LO+SW){1'b0}};
                carry_r <= 1'b0;
            end else if (en_s && vin_s[k]) begin
                sum_r   <= sum_nxt_s;
                carry_r <= c_chain_s[GPS];
            end else begin
                sum_r   <= sum_r;
                carry_r <= carry_r;
            end
        end

        if (k < STAGES - 1) begin : g_ops
            logic [IW-SW-1:0] a_rem_r;
            logic [IW-SW-1:0] b_rem_r;

            // Only the operand bits later stages still need are carried forward.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_rem_r <= {(IW-SW){1'b0}};
                    b_rem_r <= {(IW-SW){1'b0}};
                end else if (en_s && vin_s[k]) begin
                    a_rem_r <= a_in_s[IW-1:SW];
                    b_rem_r <= b_in_s[IW-1:SW];
                end else begin
                    a_rem_r <= a_rem_r;
                    b_rem_r <= b_rem_r;
                end
            end
        end else begin : g_ovf
            logic ovf_r;

            // Signed overflow: carry into the MSB disagrees with carry out of it.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_r <= 1'b0;
                end else if (en_s && vin_s[k]) begin
                    ovf_r <= c3_s[GPS-1] ^ c_chain_s[GPS];
                end else begin
                    ovf_r <= ovf_r;
                end
            end
        end
    end

    assign out_valid = valid_r[STAGES-1];
    assign out_sum   = g_stage[STAGES-1].sum_r;
    assign out_cout  = g_stage[STAGES-1].carry_r;
    assign out_ovf   = g_stage[STAGES-1].g_ovf.ovf_r;

endmodule
